// File: rtl/atom_mem_arbiter.sv
// Shares the Atom core's single-port 64 KB memory between the CPU/video port and the
// HPS ioctl download stream, holding the core in reset while a load is in flight.
module atom_mem_arbiter #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] PROG_BASE   = 16'h2900,
   parameter int          HOLD_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cpu_ce,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we_n,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_wren,
   input  logic [7:0]  mem_q,
   output logic        cpu_hold,
   output logic        load_done,
   output logic [16:0] load_count,
   output logic        load_ovf
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [16:0]       COUNT_MAX = 17'h10000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [HOLD_W-1:0]  hold_cnt_next;
   logic               dl_q;
   logic               dl_rise;
   logic               clear_stats;
   logic               done_next;

   logic [15:0]        q_addr [FIFO_DEPTH];
   logic [7:0]         q_data [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   q_count;
   logic               q_empty;
   logic               q_full;

   logic [24:0]        target;
   logic               in_range;
   logic               push;
   logic               pop;
   logic               drop;

   assign cpu_dout = mem_q;

   // Program images are relocated; anything landing above 64 KB is refused at the door.
   assign target   = (ioctl_index == 8'd0) ? ioctl_addr : ioctl_addr + {9'd0, PROG_BASE};
   assign in_range = (target[24:16] == 9'd0);

   assign q_empty = (q_count == '0);
   assign q_full  = (q_count == DEPTH_C);
   assign pop     = !cpu_ce && !q_empty;
   assign push    = ioctl_wr && in_range && (!q_full || pop);
   assign drop    = ioctl_wr && !push;
   assign dl_rise = ioctl_download && !dl_q;

   always_comb begin
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
      mem_wren = 1'b0;
      if (cpu_ce) begin
         mem_wren = ~cpu_we_n;
      end else if (!q_empty) begin
         mem_addr = q_addr[rd_ptr];
         mem_din  = q_data[rd_ptr];
         mem_wren = 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         q_addr[wr_ptr] <= target[15:0];
         q_data[wr_ptr] <= ioctl_dout;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   q_count <= q_count + CNT_W'(1);
            2'b01:   q_count <= q_count - CNT_W'(1);
            default: q_count <= q_count;
         endcase
      end
   end

   always_comb begin
      next_state    = state;
      hold_cnt_next = hold_cnt;
      clear_stats   = 1'b0;
      done_next     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dl_rise) begin
               next_state  = ST_LOAD;
               clear_stats = 1'b1;
            end
         end
         ST_LOAD: begin
            if (!ioctl_download && q_empty) begin
               next_state    = ST_SETTLE;
               hold_cnt_next = HOLD_INIT;
            end
         end
         ST_SETTLE: begin
            if (dl_rise) begin
               next_state  = ST_LOAD;
               clear_stats = 1'b1;
            end else if (hold_cnt == '0) begin
               next_state = ST_IDLE;
               done_next  = 1'b1;
            end else begin
               hold_cnt_next = hold_cnt - HOLD_W'(1);
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Hold is registered from the next state so it rises and falls with the state change.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         dl_q      <= 1'b0;
         cpu_hold  <= 1'b0;
         load_done <= 1'b0;
      end else begin
         state     <= next_state;
         hold_cnt  <= hold_cnt_next;
         dl_q      <= ioctl_download;
         cpu_hold  <= (next_state != ST_IDLE);
         load_done <= done_next;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         load_count <= '0;
         load_ovf   <= 1'b0;
      end else begin
         if (clear_stats) begin
            load_count <= '0;
         end else if (pop && load_count != COUNT_MAX) begin
            load_count <= load_count + 17'd1;
         end
         if (clear_stats) begin
            load_ovf <= drop;
         end else if (drop) begin
            load_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_atom_mem_arbiter.sv
// Randomized bench for atom_mem_arbiter: a queue-based reference model predicts the memory
// port each cycle plus the hold/load status, with directed loads, overflow and reset cases.
module tb_atom_mem_arbiter;

   localparam int HOLD = 16;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        cpu_ce;
   logic [15:0] cpu_addr;
   logic        cpu_we_n;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_wren;
   logic [7:0]  mem_q;
   logic        cpu_hold;
   logic        load_done;
   logic [16:0] load_count;
   logic        load_ovf;

   int n_checks = 0;
   int n_errors = 0;
   int done_pulses = 0;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } ent_t;

   ent_t       m_queue[$];
   logic [7:0] m_mem [0:65535];
   logic [7:0] ram   [0:65535] = '{default: 8'h00};
   int         m_phase;
   int         m_left;
   int         m_count;
   bit         m_ovf;
   bit         m_done;
   bit         m_dl_prev;
   logic [7:0] m_q;
   bit         m_q_valid;

   atom_mem_arbiter #(
      .FIFO_DEPTH  (4),
      .PROG_BASE   (16'h2900),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .cpu_ce         (cpu_ce),
      .cpu_addr       (cpu_addr),
      .cpu_we_n       (cpu_we_n),
      .cpu_din        (cpu_din),
      .cpu_dout       (cpu_dout),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_wren       (mem_wren),
      .mem_q          (mem_q),
      .cpu_hold       (cpu_hold),
      .load_done      (load_done),
      .load_count     (load_count),
      .load_ovf       (load_ovf)
   );

   always #5 clk_sys = ~clk_sys;

   // Stand-in for the spram: registered read, read-before-write.
   always @(posedge clk_sys) begin
      if (mem_wren) ram[mem_addr] <= mem_din;
      mem_q <= ram[mem_addr];
   end

   always @(posedge clk_sys) begin
      if (load_done === 1'b1) done_pulses <= done_pulses + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_queue.delete();
      m_phase   = 0;
      m_left    = 0;
      m_count   = 0;
      m_ovf     = 0;
      m_done    = 0;
      m_dl_prev = 0;
      m_q_valid = 0;
   endtask

   // One clock cycle: check registered state, drive inputs, check the memory port, advance the model.
   task automatic applyStimulus(input logic ce, input logic [15:0] ca, input logic we_n,
                                input logic [7:0] cd, input logic dl, input logic [7:0] idx,
                                input logic wr, input logic [24:0] ia, input logic [7:0] id);
      int          n;
      bit          grant_io;
      bit          rise;
      bit          drop;
      logic [15:0] exp_addr;
      logic [24:0] tgt;
      ent_t        e;
      @(negedge clk_sys);
      checkOutput("cpu_hold", cpu_hold, m_phase != 0);
      checkOutput("load_done", load_done, m_done);
      checkOutput("load_count", load_count, m_count);
      checkOutput("load_ovf", load_ovf, m_ovf);
      if (m_q_valid) checkOutput("cpu_dout", cpu_dout, m_q);
      cpu_ce         = ce;
      cpu_addr       = ca;
      cpu_we_n       = we_n;
      cpu_din        = cd;
      ioctl_download = dl;
      ioctl_index    = idx;
      ioctl_wr       = wr;
      ioctl_addr     = ia;
      ioctl_dout     = id;
      #1;
      n        = m_queue.size();
      grant_io = !ce && n > 0;
      exp_addr = grant_io ? m_queue[0].a : ca;
      checkOutput("mem_addr", mem_addr, exp_addr);
      checkOutput("mem_wren", mem_wren, ce ? !we_n : grant_io);
      if (grant_io) checkOutput("mem_din_io", mem_din, m_queue[0].d);
      else if (ce && !we_n) checkOutput("mem_din_cpu", mem_din, cd);

      m_q       = m_mem[exp_addr];
      m_q_valid = 1;
      if (ce && !we_n) m_mem[ca] = cd;
      if (grant_io) begin
         m_mem[m_queue[0].a] = m_queue[0].d;
         void'(m_queue.pop_front());
         if (m_count < 65536) m_count++;
      end
      tgt  = (idx == 8'd0) ? ia : ia + 25'h2900;
      drop = 0;
      if (wr) begin
         if (tgt > 25'h00FFFF) drop = 1;
         else if (n < 4 || grant_io) begin
            e.a = tgt[15:0];
            e.d = id;
            m_queue.push_back(e);
         end else drop = 1;
      end
      rise      = dl && !m_dl_prev;
      m_dl_prev = dl;
      m_done    = 0;
      case (m_phase)
         0: if (rise) begin m_phase = 1; m_count = 0; m_ovf = 0; end
         1: if (!dl && n == 0) begin m_phase = 2; m_left = HOLD; end
         default: begin
            if (rise) begin
               m_phase = 1; m_count = 0; m_ovf = 0;
            end else begin
               m_left--;
               if (m_left == 0) begin m_phase = 0; m_done = 1; end
            end
         end
      endcase
      if (drop) m_ovf = 1;
   endtask

   task automatic idleCycles(input int cycles, input logic dl, input logic ce);
      for (int i = 0; i < cycles; i++)
         applyStimulus(ce, 16'h0100, 1'b1, 8'h00, dl, 8'd0, 1'b0, 25'd0, 8'h00);
   endtask

   initial begin
      int bad;
      int start_pulses;
      logic dl_state;
      for (int i = 0; i < 65536; i++) m_mem[i] = 8'h00;
      modelReset();
      reset = 1'b1;
      cpu_ce = 0; cpu_addr = 0; cpu_we_n = 1; cpu_din = 0;
      ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
      #3;
      checkOutput("rst_hold", cpu_hold, 1'b0);
      checkOutput("rst_done", load_done, 1'b0);
      checkOutput("rst_count", load_count, 17'd0);
      checkOutput("rst_ovf", load_ovf, 1'b0);
      checkOutput("rst_wren", mem_wren, 1'b0);
      @(negedge clk_sys);
      @(negedge clk_sys);
      reset = 1'b0;

      $display("[TB] basic load");
      start_pulses = done_pulses;
      applyStimulus(0, 0, 1, 0, 1, 8'd0, 1, 25'h0000000, 8'hA5);
      applyStimulus(0, 0, 1, 0, 1, 8'd0, 0, 25'd0, 8'h00);
      applyStimulus(0, 0, 1, 0, 1, 8'd0, 1, 25'h000FFFF, 8'h5A);
      idleCycles(HOLD + 6, 1'b0, 1'b0);
      checkOutput("basic_mem0", ram[16'h0000], 8'hA5);
      checkOutput("basic_memffff", ram[16'hFFFF], 8'h5A);
      checkOutput("basic_count", load_count, 17'd2);
      checkOutput("basic_pulses", done_pulses - start_pulses, 1);

      $display("[TB] program offset");
      applyStimulus(0, 0, 1, 0, 1, 8'd1, 1, 25'h0000003, 8'h77);
      applyStimulus(0, 0, 1, 0, 1, 8'd1, 1, 25'h000D700, 8'h99);
      idleCycles(HOLD + 4, 1'b0, 1'b0);
      checkOutput("prog_mem", ram[16'h2903], 8'h77);
      checkOutput("prog_ovf", load_ovf, 1'b1);
      checkOutput("prog_count", load_count, 17'd1);

      $display("[TB] cpu priority and overflow");
      for (int i = 0; i < 10; i++)
         applyStimulus(1, 16'h0100 + 16'(i), 1, 0, 1, 8'd0, i < 5, 25'h0003000 + 25'(i), 8'h10 + 8'(i));
      idleCycles(6, 1'b1, 1'b0);
      checkOutput("ovf_flag", load_ovf, 1'b1);
      checkOutput("ovf_count", load_count, 17'd4);
      checkOutput("ovf_dropped", ram[16'h3004], 8'h00);
      checkOutput("ovf_first", ram[16'h3000], 8'h10);

      $display("[TB] full queue push and pop");
      idleCycles(HOLD + 4, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 16'h0200, 1, 0, 1, 8'd0, 1, 25'h0003100 + 25'(i), 8'h20 + 8'(i));
      applyStimulus(0, 0, 1, 0, 1, 8'd0, 1, 25'h0003104, 8'h24);
      idleCycles(6, 1'b1, 1'b0);
      checkOutput("full_ovf", load_ovf, 1'b0);
      checkOutput("full_count", load_count, 17'd5);
      checkOutput("full_last", ram[16'h3104], 8'h24);

      $display("[TB] reset mid-load");
      idleCycles(HOLD + 4, 1'b0, 1'b0);
      applyStimulus(1, 16'h0300, 1, 0, 1, 8'd0, 1, 25'h0001234, 8'hC1);
      applyStimulus(1, 16'h0300, 1, 0, 1, 8'd0, 1, 25'h0001235, 8'hC2);
      reset = 1'b1;
      cpu_ce = 0; ioctl_wr = 0; ioctl_download = 0;
      modelReset();
      #1;
      checkOutput("mid_rst_hold", cpu_hold, 1'b0);
      checkOutput("mid_rst_count", load_count, 17'd0);
      checkOutput("mid_rst_wren", mem_wren, 1'b0);
      @(negedge clk_sys);
      reset = 1'b0;
      idleCycles(4, 1'b0, 1'b0);
      checkOutput("mid_rst_b0", ram[16'h1234], 8'h00);
      checkOutput("mid_rst_b1", ram[16'h1235], 8'h00);

      $display("[TB] random traffic");
      dl_state = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic [24:0] ia;
         if ($urandom_range(0, 79) == 0) dl_state = ~dl_state;
         ia = ($urandom_range(0, 3) == 0) ? 25'($urandom) : 25'($urandom_range(0, 16'hFFFF));
         applyStimulus($urandom_range(0, 9) < 4, 16'($urandom), $urandom_range(0, 3) != 0,
                       8'($urandom), dl_state, 8'($urandom_range(0, 1)),
                       $urandom_range(0, 1) == 1, ia, 8'($urandom));
      end
      idleCycles(HOLD + 8, 1'b0, 1'b0);

      bad = 0;
      for (int i = 0; i < 65536; i++)
         if (ram[i] !== m_mem[i]) bad++;
      checkOutput("mem_image", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
